// File: rtl/maxpool2x2.sv
// maxpool2x2: streaming 2x2 / stride-2 max-pool over raster-order pixels, all channels in parallel.
// Defining MAXPOOL_FRAME_DONE_EN adds a registered frame_done pulse after the last pixel of a frame.
module maxpool2x2 #(
  parameter int IMAGE_WIDTH  = 26,
  parameter int IMAGE_HEIGHT = 34,
  parameter int CHANNELS     = 32,
  parameter int DATA_BITS    = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               valid_in,
  input  logic [CHANNELS-1:0][DATA_BITS-1:0] data_in,
  output logic                               valid_out,
  output logic [CHANNELS-1:0][DATA_BITS-1:0] data_out
`ifdef MAXPOOL_FRAME_DONE_EN
  ,
  output logic                               frame_done
`endif
);

  localparam int HALF_W = (IMAGE_WIDTH >= 4) ? (IMAGE_WIDTH / 2) : 2;
  localparam int IDX_W  = $clog2(HALF_W);
  localparam int COL_W  = (IMAGE_WIDTH > 2) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int ROW_W  = (IMAGE_HEIGHT > 2) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);

  typedef logic [CHANNELS-1:0][DATA_BITS-1:0] pix_t;

  function automatic logic [DATA_BITS-1:0] smax(input logic [DATA_BITS-1:0] a,
                                                input logic [DATA_BITS-1:0] b);
    if ($signed(a) >= $signed(b)) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  pix_t             hreg_q, hreg_d;
  pix_t             data_q, data_d;
  logic             valid_q, valid_d;
  pix_t             lbuf_q [HALF_W];

  logic             last_col_s, last_row_s, lbuf_we_s;
  logic [IDX_W-1:0] lbuf_idx_s;
  pix_t             pair_s, pool_s;

  // Window datapath and next-state for counters, pair register and output
  always_comb begin
    last_col_s = (col_q == COL_LAST);
    last_row_s = (row_q == ROW_LAST);
    lbuf_idx_s = IDX_W'(col_q >> 1);
    for (int ch = 0; ch < CHANNELS; ch++) begin
      pair_s[ch] = smax(hreg_q[ch], data_in[ch]);
      pool_s[ch] = smax(lbuf_q[lbuf_idx_s][ch], pair_s[ch]);
    end
    col_d     = col_q;
    row_d     = row_q;
    hreg_d    = hreg_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    lbuf_we_s = 1'b0;
    if (valid_in) begin
      if (last_col_s) begin
        col_d = '0;
        row_d = last_row_s ? '0 : (row_q + ROW_W'(1));
      end else begin
        col_d = col_q + COL_W'(1);
      end
      // An odd last column or odd last row never reaches the pooling branch
      if (!col_q[0]) begin
        hreg_d = data_in;
      end else if (row_q[0]) begin
        data_d  = pool_s;
        valid_d = 1'b1;
      end else begin
        lbuf_we_s = 1'b1;
      end
    end else begin
      lbuf_we_s = 1'b0;
    end
  end

  // Counters, pair register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      hreg_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      hreg_q  <= hreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Line buffer needs no reset: each entry is rewritten on an even row before the odd row reads it
  always_ff @(posedge clk) begin
    if (lbuf_we_s) begin
      lbuf_q[lbuf_idx_s] <= pair_s;
    end else begin
      lbuf_q[lbuf_idx_s] <= lbuf_q[lbuf_idx_s];
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;

`ifdef MAXPOOL_FRAME_DONE_EN
  logic done_q;

  // One-cycle pulse after the final pixel of the frame is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= valid_in & last_col_s & last_row_s;
    end
  end

  assign frame_done = done_q;
`endif

endmodule

// File: tb/tb_maxpool2x2.sv
// Bench for maxpool2x2: frame-image reference model checked every cycle, plus literal pins
// on a 26x34x32 instance and a small odd-dimension 5x3 instance.
module tb_maxpool2x2;

  localparam int W = 26;
  localparam int H = 34;

  typedef logic [31:0][31:0] pix_t;
  typedef logic [1:0][7:0]   spix_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  valid;
  pix_t  din;
  logic  vout;
  pix_t  dout;
  logic  done;
  logic  sm_valid;
  spix_t sm_din;
  logic  sm_vout;
  spix_t sm_dout;
  logic  sm_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  maxpool2x2 dut (
    .clk(clk), .rst(rst), .valid_in(valid), .data_in(din),
    .valid_out(vout), .data_out(dout)
`ifdef MAXPOOL_FRAME_DONE_EN
    , .frame_done(done)
`endif
  );

  maxpool2x2 #(.IMAGE_WIDTH(5), .IMAGE_HEIGHT(3), .CHANNELS(2), .DATA_BITS(8)) sdut (
    .clk(clk), .rst(rst), .valid_in(sm_valid), .data_in(sm_din),
    .valid_out(sm_vout), .data_out(sm_dout)
`ifdef MAXPOOL_FRAME_DONE_EN
    , .frame_done(sm_done)
`endif
  );

`ifndef MAXPOOL_FRAME_DONE_EN
  assign done    = 1'b0;
  assign sm_done = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  function automatic pix_t pixval(input int mode, input int r, input int c);
    pix_t p;
    for (int ch = 0; ch < 32; ch++) p[ch] = 32'(r * W + c);
    if (mode == 1) begin
      p[31] = 32'h0000_0000;
      if (r < 2 && c < 2) begin
        if (r == 0) p[0] = (c == 0) ? 32'hFFFF_FFFB : 32'hFFFF_FFFD;
        else        p[0] = (c == 0) ? 32'hFFFF_FFF9 : 32'hFFFF_FFFF;
      end else begin
        p[0] = 32'(-(r * W + c));
      end
    end
    return p;
  endfunction

  function automatic pix_t win_max(input pix_t a, input pix_t b, input pix_t c, input pix_t d);
    pix_t m;
    for (int ch = 0; ch < 32; ch++) begin
      m[ch] = a[ch];
      if ($signed(b[ch]) > $signed(m[ch])) m[ch] = b[ch];
      if ($signed(c[ch]) > $signed(m[ch])) m[ch] = c[ch];
      if ($signed(d[ch]) > $signed(m[ch])) m[ch] = d[ch];
    end
    return m;
  endfunction

  // Reference model: remembers the whole frame and pools each completed 2x2 window
  pix_t img [H][W];
  int   mr, mc;
  logic exp_valid, exp_done;
  pix_t exp_data;
  always @(posedge clk) begin
    if (rst) begin
      mr <= 0; mc <= 0; exp_valid <= 1'b0; exp_done <= 1'b0; exp_data <= '0;
    end else begin
      exp_valid <= 1'b0;
      exp_done  <= 1'b0;
      if (valid) begin
        img[mr][mc] <= din;
        if ((mr % 2 == 1) && (mc % 2 == 1)) begin
          exp_valid <= 1'b1;
          exp_data  <= win_max(img[mr-1][mc-1], img[mr-1][mc], img[mr][mc-1], din);
        end
        if (mc == W - 1) begin
          mc <= 0;
          mr <= (mr == H - 1) ? 0 : mr + 1;
`ifdef MAXPOOL_FRAME_DONE_EN
          exp_done <= (mr == H - 1);
`endif
        end else begin
          mc <= mc + 1;
        end
      end
    end
  end

  // Per-cycle compare and output capture
  logic [31:0] cap0 [$];
  logic [31:0] cap31 [$];
  logic [15:0] sm_cap [$];
  int done_cnt = 0;
  int sm_done_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("valid_out", {31'd0, vout}, {31'd0, exp_valid});
        check("frame_done", {31'd0, done}, {31'd0, exp_done});
        total++;
        if (dout !== exp_data) begin
          bad++;
          for (int ch = 0; ch < 32; ch++)
            if (dout[ch] !== exp_data[ch]) begin
              $display("FAIL data_out ch%0d got=%h want=%h at %0t", ch, dout[ch], exp_data[ch], $time);
              break;
            end
        end
        if (vout) begin
          cap0.push_back(dout[0]);
          cap31.push_back(dout[31]);
        end
        if (done) done_cnt++;
        if (sm_vout) sm_cap.push_back(sm_dout);
        if (sm_done) sm_done_cnt++;
      end
    end
  end

  task automatic send_frame(input int mode, input int start, input int n, input int duty);
    for (int i = start; i < start + n; i++) begin
      while ($urandom_range(0, 99) >= duty) begin
        valid = 1'b0;
        din   = pixval(0, 33, 25);
        @(posedge clk); #1;
      end
      valid = 1'b1;
      din   = pixval(mode, (i / W) % H, i % W);
      @(posedge clk); #1;
    end
    valid = 1'b0;
  endtask

  task automatic check_ramp(input string name, input int n0, input int cnt);
    check({name, " count"}, 32'(cap0.size() - n0), 32'(cnt));
    if (cap0.size() >= n0 + cnt && cnt > 0) begin
      check({name, " first ch0"}, cap0[n0], 32'd27);
      check({name, " first ch31"}, cap31[n0], 32'd27);
      check({name, " last ch0"}, cap0[cap0.size() - 1], 32'd883);
    end else begin
      check({name, " outputs missing"}, 32'(cap0.size() - n0), 32'(n0 + cnt));
    end
  endtask

  int n0, d0;

  initial begin
    rst = 1'b1; valid = 1'b0; din = '0; sm_valid = 1'b0; sm_din = '0;
    repeat (2) @(posedge clk); #1;
    valid = 1'b1; din = pixval(0, 1, 1);
    sm_valid = 1'b1; sm_din = 16'h1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset valid_out", {31'd0, vout}, 32'd0);
    check("reset data_out ch0", dout[0], 32'd0);
    check("reset data_out ch31", dout[31], 32'd0);
    check("reset frame_done", {31'd0, done}, 32'd0);
    check("reset small data_out", {16'd0, sm_dout}, 32'd0);
    @(posedge clk); #1;
    valid = 1'b0; sm_valid = 1'b0;
    rst = 1'b0;

    n0 = cap0.size();
    send_frame(0, 0, W * H, 100);
    repeat (3) @(posedge clk); #1;
    check_ramp("ramp", n0, 221);

    n0 = cap0.size();
    send_frame(1, 0, 2 * W, 100);
    repeat (3) @(posedge clk); #1;
    check("signed count", 32'(cap0.size() - n0), 32'd13);
    if (cap0.size() > n0) begin
      check("signed ch0", cap0[n0], 32'hFFFF_FFFF);
      check("signed ch31", cap31[n0], 32'd0);
    end else begin
      check("signed output missing", 32'(cap0.size()), 32'(n0 + 1));
    end
    send_frame(1, 2 * W, 7 * W + 5, 100);
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    n0 = cap0.size();
    send_frame(0, 0, W * H, 100);
    repeat (3) @(posedge clk); #1;
    check_ramp("after reset", n0, 221);

    n0 = cap0.size();
    send_frame(0, 0, W * H, 40);
    repeat (3) @(posedge clk); #1;
    check_ramp("gaps", n0, 221);

    n0 = cap0.size();
    d0 = done_cnt;
    send_frame(0, 0, 2 * W * H, 100);
    repeat (3) @(posedge clk); #1;
    check("b2b count", 32'(cap0.size() - n0), 32'd442);
`ifdef MAXPOOL_FRAME_DONE_EN
    check("b2b frame_done count", 32'(done_cnt - d0), 32'd2);
`endif

    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 15; i++) begin
        sm_valid  = 1'b1;
        sm_din[0] = 8'(i);
        sm_din[1] = 8'(-i);
        @(posedge clk); #1;
      end
    sm_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("small count", 32'(sm_cap.size()), 32'd4);
    if (sm_cap.size() == 4) begin
      check("small w0", {16'd0, sm_cap[0]}, 32'h0000_0006);
      check("small w1", {16'd0, sm_cap[1]}, 32'h0000_FE08);
      check("small f2 w0", {16'd0, sm_cap[2]}, 32'h0000_0006);
      check("small f2 w1", {16'd0, sm_cap[3]}, 32'h0000_FE08);
    end else begin
      check("small outputs missing", 32'(sm_cap.size()), 32'd4);
    end
`ifdef MAXPOOL_FRAME_DONE_EN
    check("small frame_done count", 32'(sm_done_cnt), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
